// File: rtl/pong_pkg.sv
// Shared constants and types for the pong ball path: screen defaults,
// sprite size, motion FSM states and the axis direction encoding.
package pong_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int BALL_SIZE    = 8;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    RESPAWN
  } state_t;

  // DIR_INC is right on X and down on Y; DIR_DEC is left on X and up on Y.
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

  function automatic dir_t flip_dir(input dir_t d);
    return (d == DIR_INC) ? DIR_DEC : DIR_INC;
  endfunction

endpackage

// File: rtl/ball_renderer_if.sv
// Video timing bundle from the VGA sync generator to the ball renderer.
interface ball_renderer_if;

  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_tick;

  modport master (
    output video_on,
    output pixel_x,
    output pixel_y,
    output frame_tick
  );

  modport slave (
    input video_on,
    input pixel_x,
    input pixel_y,
    input frame_tick
  );

endinterface

// File: rtl/ball_motion.sv
// Ball motion FSM: one position update per frame_tick, wall bounces on Y,
// miss detection on X and a parked respawn period at screen centre.
module ball_motion
  import pong_pkg::*;
#(
  parameter int H_ACTIVE       = DEF_H_ACTIVE,
  parameter int V_ACTIVE       = DEF_V_ACTIVE,
  parameter int SPEED          = 2,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       paddle_hit,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       miss_left,
  output logic       miss_right
);

  localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

  localparam logic [9:0]       X_C      = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]       Y_C      = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]       Y_MAX    = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]       STEP     = 10'(SPEED);
  localparam logic [10:0]      REACH    = 11'(BALL_SIZE + SPEED);
  localparam logic [10:0]      H_LIM    = 11'(H_ACTIVE);
  localparam logic [10:0]      V_LIM    = 11'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);

  state_t           state;
  dir_t             dir_x;
  dir_t             dir_y;
  logic [CNT_W-1:0] frame_cnt;

  // A paddle hit reverses X before the edge checks, so a save at the wall
  // turns the ball around instead of scoring a miss.
  dir_t        dir_x_eff;
  logic [10:0] x_far;
  logic [10:0] y_far;
  logic        hit_left;
  logic        hit_right;
  logic        hit_top;
  logic        hit_bottom;

  assign dir_x_eff  = paddle_hit ? flip_dir(dir_x) : dir_x;
  assign x_far      = {1'b0, ball_x} + REACH;
  assign y_far      = {1'b0, ball_y} + REACH;
  assign hit_left   = (dir_x_eff == DIR_DEC) && (ball_x <= STEP);
  assign hit_right  = (dir_x_eff == DIR_INC) && (x_far >= H_LIM);
  assign hit_top    = (dir_y == DIR_DEC) && (ball_y <= STEP);
  assign hit_bottom = (dir_y == DIR_INC) && (y_far >= V_LIM);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ball_x     <= X_C;
      ball_y     <= Y_C;
      dir_x      <= DIR_INC;
      dir_y      <= DIR_INC;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        ball_x    <= X_C;
        ball_y    <= Y_C;
        frame_cnt <= '0;
      end else if (frame_tick) begin
        case (state)
          IDLE: state <= MOVE;
          MOVE: begin
            dir_x <= dir_x_eff;
            if (hit_left) begin
              miss_left <= 1'b1;
              ball_x    <= X_C;
              ball_y    <= Y_C;
              dir_x     <= DIR_INC;
              state     <= RESPAWN;
            end else if (hit_right) begin
              miss_right <= 1'b1;
              ball_x     <= X_C;
              ball_y     <= Y_C;
              dir_x      <= DIR_DEC;
              state      <= RESPAWN;
            end else begin
              ball_x <= (dir_x_eff == DIR_INC) ? ball_x + STEP : ball_x - STEP;
              if (hit_top) begin
                ball_y <= '0;
                dir_y  <= DIR_INC;
              end else if (hit_bottom) begin
                ball_y <= Y_MAX;
                dir_y  <= DIR_DEC;
              end else begin
                ball_y <= (dir_y == DIR_INC) ? ball_y + STEP : ball_y - STEP;
              end
            end
          end
          RESPAWN: begin
            if (frame_cnt == CNT_LAST) begin
              frame_cnt <= '0;
              state     <= MOVE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ball_renderer.sv
// Ball renderer: owns the ball motion and turns the current scan position
// into a registered per-pixel ball_on flag using the external sprite ROM.
module ball_renderer
  import pong_pkg::*;
#(
  parameter int H_ACTIVE       = DEF_H_ACTIVE,
  parameter int V_ACTIVE       = DEF_V_ACTIVE,
  parameter int SPEED          = 2,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ball_renderer_if.slave        vid,
  input  logic                  enable,
  input  logic                  paddle_hit,
  output logic [2:0]            ball_rom_addr,
  input  logic [BALL_SIZE-1:0]  ball_rom_data,
  output logic                  ball_on,
  output logic [9:0]            ball_x,
  output logic [9:0]            ball_y,
  output logic                  miss_left,
  output logic                  miss_right
);

  ball_motion #(
    .H_ACTIVE       (H_ACTIVE),
    .V_ACTIVE       (V_ACTIVE),
    .SPEED          (SPEED),
    .RESPAWN_FRAMES (RESPAWN_FRAMES)
  ) u_motion (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (vid.frame_tick),
    .enable     (enable),
    .paddle_hit (paddle_hit),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .miss_left  (miss_left),
    .miss_right (miss_right)
  );

  // Offsets wrap when the scan is left of / above the ball, hence the
  // explicit >= checks alongside the < BALL_SIZE window test.
  logic [9:0] dx;
  logic [9:0] dy;
  logic       in_box;
  logic       sprite_bit;

  assign dx            = vid.pixel_x - ball_x;
  assign dy            = vid.pixel_y - ball_y;
  assign in_box        = (vid.pixel_y >= ball_y) && (dy < 10'(BALL_SIZE)) &&
                         (vid.pixel_x >= ball_x) && (dx < 10'(BALL_SIZE));
  assign ball_rom_addr = dy[2:0];
  assign sprite_bit    = ball_rom_data[3'd7 - dx[2:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ball_on <= 1'b0;
    end else begin
      ball_on <= vid.video_on && in_box && sprite_bit;
    end
  end

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: reset, render taps, bounce, miss,
// respawn, enable drop, async reset and paddle save.
module tb_ball_renderer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       paddle_hit = 1'b0;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic       ball_on;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       miss_left;
  logic       miss_right;

  int checks = 0;
  int errors = 0;

  ball_renderer_if vid ();

  ball_renderer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .vid           (vid),
    .enable        (enable),
    .paddle_hit    (paddle_hit),
    .ball_rom_addr (rom_addr),
    .ball_rom_data (rom_data),
    .ball_on       (ball_on),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .miss_left     (miss_left),
    .miss_right    (miss_right)
  );

  always #5 clk = ~clk;

  // Round sprite with blank corners.
  always_comb begin
    rom_data = 8'h00;
    case (rom_addr)
      3'd0, 3'd7: rom_data = 8'b0011_1100;
      3'd1, 3'd6: rom_data = 8'b0111_1110;
      default:    rom_data = 8'b1111_1111;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic hit);
    @(negedge clk);
    vid.frame_tick = 1'b1;
    paddle_hit     = hit;
    @(posedge clk);
    #1;
    vid.frame_tick = 1'b0;
    paddle_hit     = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic pix(input int x, input int y, input logic von);
    @(negedge clk);
    vid.pixel_x  = 10'(x);
    vid.pixel_y  = 10'(y);
    vid.video_on = von;
    step();
  endtask

  initial begin
    vid.video_on   = 1'b0;
    vid.pixel_x    = '0;
    vid.pixel_y    = '0;
    vid.frame_tick = 1'b0;

    #23 reset_n = 1'b1;
    step();
    check("reset_x", 32'(ball_x), 32'd316);
    check("reset_y", 32'(ball_y), 32'd236);
    check("reset_on", 32'(ball_on), 32'd0);
    check("reset_miss", 32'({miss_left, miss_right}), 32'd0);

    // Render taps with the ball at (316, 236).
    pix(316, 236, 1'b1); check("pix_corner", 32'(ball_on), 32'd0);
    pix(319, 236, 1'b1); check("pix_top_mid", 32'(ball_on), 32'd1);
    pix(316, 238, 1'b1); check("pix_left_edge", 32'(ball_on), 32'd1);
    pix(324, 238, 1'b1); check("pix_right_out", 32'(ball_on), 32'd0);
    pix(315, 238, 1'b1); check("pix_left_out", 32'(ball_on), 32'd0);
    pix(319, 236, 1'b0); check("pix_blank", 32'(ball_on), 32'd0);
    pix(0, 0, 1'b0);

    // First tick only enters MOVE; second tick moves.
    enable = 1'b1;
    tick(1'b0);
    check("idle_to_move_x", 32'(ball_x), 32'd316);
    tick(1'b0);
    check("move1_x", 32'(ball_x), 32'd318);
    check("move1_y", 32'(ball_y), 32'd238);

    // Bottom bounce: 470 -> 472 (turn up) -> 470.
    ticks(116);
    check("pre_bounce_y", 32'(ball_y), 32'd470);
    tick(1'b0);
    check("bounce_y", 32'(ball_y), 32'd472);
    tick(1'b0);
    check("after_bounce_y", 32'(ball_y), 32'd470);
    check("after_bounce_x", 32'(ball_x), 32'd554);

    // Right miss from x = 630.
    ticks(38);
    check("pre_miss_x", 32'(ball_x), 32'd630);
    check("pre_miss_y", 32'(ball_y), 32'd394);
    tick(1'b0);
    check("miss_right_pulse", 32'(miss_right), 32'd1);
    check("miss_left_quiet", 32'(miss_left), 32'd0);
    check("miss_recentre_x", 32'(ball_x), 32'd316);
    check("miss_recentre_y", 32'(ball_y), 32'd236);
    step();
    check("miss_right_width", 32'(miss_right), 32'd0);

    // Parked for 60 ticks, then moving left (Y still heading up).
    ticks(60);
    check("respawn_hold_x", 32'(ball_x), 32'd316);
    check("respawn_hold_y", 32'(ball_y), 32'd236);
    tick(1'b0);
    check("respawn_exit_x", 32'(ball_x), 32'd314);
    check("respawn_exit_y", 32'(ball_y), 32'd234);

    // Enable drop recentres on the next clk; ticks are ignored while off.
    @(negedge clk);
    enable = 1'b0;
    step();
    check("disable_x", 32'(ball_x), 32'd316);
    check("disable_y", 32'(ball_y), 32'd234 + 32'd2);
    tick(1'b0);
    tick(1'b0);
    check("disabled_tick_x", 32'(ball_x), 32'd316);

    // Re-enable: directions survived the drop (left, up).
    enable = 1'b1;
    tick(1'b0);
    check("reenable_idle_x", 32'(ball_x), 32'd316);
    tick(1'b0);
    check("dir_kept_x", 32'(ball_x), 32'd314);
    check("dir_kept_y", 32'(ball_y), 32'd234);

    // Async reset mid-line clears ball_on without a clock edge.
    @(negedge clk);
    enable = 1'b0;
    step();
    pix(316, 238, 1'b1);
    check("pre_reset_on", 32'(ball_on), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_on", 32'(ball_on), 32'd0);
    check("async_reset_x", 32'(ball_x), 32'd316);
    @(negedge clk);
    vid.video_on = 1'b0;
    reset_n = 1'b1;

    // Paddle save at x = 630: no miss, ball turns left.
    enable = 1'b1;
    tick(1'b0);
    ticks(157);
    check("save_pre_x", 32'(ball_x), 32'd630);
    tick(1'b1);
    check("save_no_miss", 32'({miss_left, miss_right}), 32'd0);
    check("save_x", 32'(ball_x), 32'd628);
    check("save_y", 32'(ball_y), 32'd392);
    tick(1'b0);
    check("save_dir_x", 32'(ball_x), 32'd626);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_renderer.md
# ball_renderer

Moves the 8×8 ball once per video frame and renders it onto the VGA pixel stream. It drives the row address of the combinational 8×8 ball sprite ROM (`ball`) and reads back 8-bit row data. It outputs a per-pixel `ball_on` flag to the colour mux, plus the ball position and miss pulses to the score logic. It sits between the VGA sync generator and the pixel colour mux in the pong top level.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SPEED, 2, pixels moved per frame on each axis (1..7)
- RESPAWN_FRAMES, 60, frames parked at centre after a miss

Ports:
- clk  in  1  pixel clock; one clock domain only
- reset_n  in  1  asynchronous, active-low reset
- video_on  in  1  high during the visible area
- pixel_x  in  10  current scan column
- pixel_y  in  10  current scan row
- frame_tick  in  1  one-cycle pulse at the start of vertical blanking
- enable  in  1  game running
- paddle_hit  in  1  level; sampled only on frame_tick
- ball_rom_addr  out  3  sprite row address (combinational)
- ball_rom_data  in  8  sprite row; bit 7 is the leftmost pixel
- ball_on  out  1  ball pixel opaque at the pixel presented 1 cycle earlier
- ball_x  out  10  left edge of the ball, registered
- ball_y  out  10  top edge of the ball, registered
- miss_left  out  1  one-cycle pulse
- miss_right  out  1  one-cycle pulse

## Operation
- Centre position: X_C = H_ACTIVE/2−4 and Y_C = V_ACTIVE/2−4, i.e. 316 and 236 with defaults.
- Reset values:
  - state IDLE
  - ball_x = X_C, ball_y = Y_C
  - dir_x = right, dir_y = down
  - ball_on = 0, miss_left = 0, miss_right = 0
  - frame counter = 0
- FSM states: IDLE, MOVE, RESPAWN.
  - IDLE: ball held at centre. Go to MOVE on frame_tick while enable = 1.
  - MOVE: one position update per frame_tick, as described below.
  - RESPAWN: ball held at centre. The counter increments per frame_tick. Go to MOVE on the frame_tick where the counter reaches RESPAWN_FRAMES−1; the counter clears on exit.
  - From any state, enable = 0 → IDLE on the next clk and ball recentred. dir_x and dir_y are kept.
- MOVE update, all on the frame_tick cycle:
  - Step 1: if paddle_hit = 1, dir_x flips before any edge check.
  - Step 2, X axis:
    - If dir_x = left and ball_x ≤ SPEED: miss_left pulses, ball recentred, dir_x set to right, state → RESPAWN.
    - If dir_x = right and ball_x + 8 + SPEED ≥ H_ACTIVE: miss_right pulses, ball recentred, dir_x set to left, state → RESPAWN.
    - Otherwise ball_x ± SPEED.
  - Step 3, Y axis:
    - If dir_y = up and ball_y ≤ SPEED: ball_y = 0 and dir_y = down.
    - If dir_y = down and ball_y + 8 + SPEED ≥ V_ACTIVE: ball_y = V_ACTIVE−8 and dir_y = up.
    - Otherwise ball_y ± SPEED.
    - The Y update is skipped when a miss occurs.
  - X and Y evaluate independently, so corner bounces flip both directions in the same frame.
- Render path:
  - dy = pixel_y − ball_y and dx = pixel_x − ball_x, both 10-bit unsigned.
  - in_box = (pixel_y ≥ ball_y) && (dy < 8) && (pixel_x ≥ ball_x) && (dx < 8).
  - ball_rom_addr = dy[2:0] (combinational).
  - Registered: ball_on ← video_on && in_box && ball_rom_data[7 − dx[2:0]].
- All arithmetic is 10-bit unsigned. Edge comparisons use 11-bit sums so they cannot wrap.

## Timing
- ball_on latency is 1 clk from pixel_x/pixel_y/video_on. The VGA pipeline delays its colour select by 1 clk to match.
- The position changes only in the cycle after frame_tick, which falls inside blanking, so there is no tearing within a frame.
- miss_left and miss_right assert in the cycle after frame_tick and are exactly 1 clk wide. At most one asserts per frame.
- frame_tick while enable = 0 has no effect.
- Reset asserted mid-frame forces all outputs to their reset values asynchronously. After release, motion resumes only after IDLE → MOVE on a frame_tick.

## Structure
- Package `pong_pkg` holds:
  - H_ACTIVE and V_ACTIVE defaults
  - BALL_SIZE = 8
  - the state typedef {IDLE, MOVE, RESPAWN}
  - the direction encoding
- Sub-module `ball_motion` contains the FSM, position registers, directions and respawn counter. It outputs ball_x, ball_y and the miss pulses.
- `ball_renderer` instantiates `ball_motion` and implements the render path.
- The sprite ROM is instantiated by the parent and connects through ball_rom_addr and ball_rom_data.

## Test plan
- Reset then release:
  - ball_x = 316, ball_y = 236, ball_on = 0.
  - With enable = 1, the first frame_tick enters MOVE. The second frame_tick gives ball_x = 318, ball_y = 238.
- Render at ball at (316, 236):
  - pixel (316, 236) → ball_on = 0 one clk later; it is a blank sprite corner.
  - (319, 236) → 1; (316, 238) → 1; (324, 238) → 0.
  - video_on = 0 always gives 0.
- Bottom bounce: ball_y = 470 with dir_y down → next frame ball_y = 472 and dir_y up. The following frame gives ball_y = 470.
- Right miss:
  - ball_x = 630 moving right, paddle_hit = 0 → miss_right pulses for 1 clk and the ball moves to centre.
  - The ball stays at centre for 60 frame_ticks, then moves left.
- Paddle save: ball_x = 630 moving right, paddle_hit = 1 → no miss, dir_x = left, ball_x = 628.
- enable dropped in MOVE → IDLE and centre on the next clk. Reset asserted mid-line → ball_on = 0 immediately.
